rc_stream_wrapper: RTL

RC_STREAM_WRAPPER -- requirements
Module: rc_stream_wrapper

---
 rtl/rc_stream_wrapper.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/rc_stream_wrapper.sv
`default_nettype none
// ============================================================================
// Module   : rc_stream_wrapper
// Purpose  : Word-serial stream adapter around a batched permutation core.
//            Collects TOTAL = STATE_SIZE*BATCH words into a registered input
//            buffer, pulses the core, captures the whole result on perm_done,
//            then streams the result out one word at a time.
// Ports    : clk, reset (async, active-high), clear (sync job abort)
//            in_data/in_valid/in_ready     - input word stream
//            out_data/out_valid/out_ready  - output word stream
//            perm_in/perm_start            - flattened state + start pulse
//            perm_out/perm_done            - flattened result + done pulse
//            busy                          - job in START/WAIT/UNLOAD
//            Word k lives at bits [(k+1)*N_BITS-1 : k*N_BITS] of perm_in/out.
// Revision : 1.0 - initial release
// ============================================================================
module rc_stream_wrapper #(
  parameter int STATE_SIZE = 3,
  parameter int N_BITS     = 254,
  parameter int BATCH      = 13
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                clear,
  input  logic [N_BITS-1:0]                   in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [N_BITS-1:0]                   out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [STATE_SIZE*BATCH*N_BITS-1:0]  perm_in,
  output logic                                perm_start,
  input  logic                                perm_done,
  input  logic [STATE_SIZE*BATCH*N_BITS-1:0]  perm_out,
  output logic                                busy
);

  localparam int                 C_TOTAL = STATE_SIZE * BATCH;
  localparam int                 C_PTR_W = $clog2(C_TOTAL + 1);
  localparam logic [C_PTR_W-1:0] C_LAST  = C_PTR_W'(C_TOTAL - 1);
  localparam logic [C_PTR_W-1:0] C_ONE   = C_PTR_W'(1);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_START  = 2'd1,
    S_WAIT   = 2'd2,
    S_UNLOAD = 2'd3
  } state_t;

  state_t              r_state;
  logic [C_PTR_W-1:0]  r_wr_ptr;
  logic [C_PTR_W-1:0]  r_rd_ptr;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_perm_start;
  logic                r_busy;
  logic [N_BITS-1:0]   r_in_buf  [C_TOTAL];
  logic [N_BITS-1:0]   r_out_buf [C_TOTAL];

  logic                w_in_xfer;
  logic                w_out_xfer;
  logic                w_capture;

  // Handshake qualifiers use only registered ready/valid, so there is no
  // combinational path from in_valid to in_ready or out_ready to out_valid.
  assign w_in_xfer  = in_valid  & r_in_ready;
  assign w_out_xfer = out_ready & r_out_valid;
  assign w_capture  = (r_state == S_WAIT) & perm_done;

  // Control FSM; every handshake/status output is a register updated
  // together with the state so it always matches the state it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_LOAD;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_perm_start <= 1'b0;
      r_busy       <= 1'b0;
    end else if (clear) begin
      // Abort wins over any handshake on the same edge.
      r_state      <= S_LOAD;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_perm_start <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_in_xfer) begin
            r_wr_ptr <= r_wr_ptr + C_ONE;
            if (r_wr_ptr == C_LAST) begin
              r_state      <= S_START;
              r_in_ready   <= 1'b0;
              r_perm_start <= 1'b1;
              r_busy       <= 1'b1;
            end
          end
        end
        S_START: begin
          r_state      <= S_WAIT;
          r_perm_start <= 1'b0;
        end
        S_WAIT: begin
          if (perm_done) begin
            r_state     <= S_UNLOAD;
            r_out_valid <= 1'b1;
          end
        end
        S_UNLOAD: begin
          if (w_out_xfer) begin
            if (r_rd_ptr == C_LAST) begin
              r_state     <= S_LOAD;
              r_wr_ptr    <= '0;
              r_rd_ptr    <= '0;
              r_out_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_in_ready  <= 1'b1;
            end else begin
              r_rd_ptr <= r_rd_ptr + C_ONE;
            end
          end
        end
        default: begin
          r_state      <= S_LOAD;
          r_wr_ptr     <= '0;
          r_rd_ptr     <= '0;
          r_in_ready   <= 1'b1;
          r_out_valid  <= 1'b0;
          r_perm_start <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  // Data buffers carry no reset: their contents are meaningless until the
  // pointers/state say otherwise. wr_ptr only indexes while in LOAD, where
  // it is always below TOTAL.
  always_ff @(posedge clk) begin
    if (!clear && w_in_xfer) begin
      r_in_buf[r_wr_ptr] <= in_data;
    end
    if (!clear && w_capture) begin
      for (int k = 0; k < C_TOTAL; k++) begin
        r_out_buf[k] <= perm_out[k*N_BITS +: N_BITS];
      end
    end
  end

  for (genvar g = 0; g < C_TOTAL; g++) begin : g_flatten
    assign perm_in[g*N_BITS +: N_BITS] = r_in_buf[g];
  end

  assign out_data   = r_out_buf[r_rd_ptr];
  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign perm_start = r_perm_start;
  assign busy       = r_busy;

endmodule
`default_nettype wire
